// File: rtl/game_status_tracker.sv
// Scoring, lives and end-of-level detection for the game control FSM.
// Gameplay events are honoured only while the control unit reports the Level state.
module game_status_tracker #(
    parameter int unsigned NUM_PELLETS   = 240,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned POWER_FRAMES  = 360,
    parameter int unsigned GRACE_FRAMES  = 120,
    parameter int unsigned PELLET_POINTS = 10,
    parameter int unsigned POWER_POINTS  = 50,
    parameter int unsigned GHOST_POINTS  = 200
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [1:0]  game_state,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_collide,
    output logic        Win,
    output logic        loss,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic        power_mode,
    output logic        respawn
);

    typedef enum logic [1:0] {IDLE, PLAY, GRACE, DONE} state_t;

    localparam logic [1:0] GS_START = 2'b00;
    localparam logic [1:0] GS_LEVEL = 2'b01;

    state_t      state, state_n;
    logic [8:0]  pellets_left, pellets_n;
    logic [9:0]  power_timer, power_n;
    logic [9:0]  grace_timer, grace_n;
    logic [15:0] score_n, add;
    logic [16:0] score_sum;
    logic [1:0]  lives_n;
    logic        win_n, loss_n, respawn_n;
    logic        pellet_hit, collide, clear;

    always_comb begin
        state_n    = state;
        pellets_n  = pellets_left;
        power_n    = power_timer;
        grace_n    = grace_timer;
        score_n    = score;
        lives_n    = lives;
        win_n      = Win;
        loss_n     = loss;
        respawn_n  = 1'b0;
        add        = '0;
        score_sum  = '0;
        pellet_hit = 1'b0;
        collide    = 1'b0;
        clear      = 1'b0;

        case (state)
            IDLE: begin
                clear = 1'b1;
                if (game_state == GS_LEVEL) state_n = PLAY;
            end
            PLAY, GRACE: begin
                if (game_state == GS_LEVEL) begin
                    pellet_hit = (pellet_eaten || power_eaten) && (pellets_left != '0);
                    if (pellet_hit) begin
                        pellets_n = pellets_left - 9'd1;
                        add = power_eaten ? 16'(POWER_POINTS) : 16'(PELLET_POINTS);
                    end
                    if (pellet_hit && power_eaten)
                        power_n = 10'(POWER_FRAMES);
                    else if (frame_tick && power_timer != '0)
                        power_n = power_timer - 10'd1;

                    if (state == GRACE && frame_tick) begin
                        grace_n = grace_timer - 10'd1;
                        if (grace_timer == 10'd1) state_n = PLAY;
                    end

                    // A lethal hit in the same cycle as the last pellet is dropped: Win outranks loss.
                    collide = (state == PLAY) && frame_tick && ghost_collide;
                    if (collide && power_timer != '0) begin
                        add     = add + 16'(GHOST_POINTS);
                        grace_n = 10'(GRACE_FRAMES);
                        state_n = GRACE;
                    end else if (collide && pellets_n != '0) begin
                        if (lives != '0) lives_n = lives - 2'd1;
                        respawn_n = 1'b1;
                        power_n   = '0;
                        grace_n   = 10'(GRACE_FRAMES);
                        state_n   = GRACE;
                    end

                    score_sum = {1'b0, score} + {1'b0, add};
                    score_n   = score_sum[16] ? '1 : score_sum[15:0];

                    if (pellets_n == '0) begin
                        win_n   = 1'b1;
                        state_n = DONE;
                    end else if (lives_n == '0) begin
                        loss_n  = 1'b1;
                        state_n = DONE;
                    end
                end else if (game_state == GS_START) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end
            end
            DONE: begin
                if (game_state == GS_START) begin
                    clear   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (clear) begin
            pellets_n = 9'(NUM_PELLETS);
            power_n   = '0;
            grace_n   = '0;
            score_n   = '0;
            lives_n   = 2'(START_LIVES);
            win_n     = 1'b0;
            loss_n    = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= IDLE;
            pellets_left <= 9'(NUM_PELLETS);
            power_timer  <= '0;
            grace_timer  <= '0;
            score        <= '0;
            lives        <= 2'(START_LIVES);
            Win          <= 1'b0;
            loss         <= 1'b0;
            power_mode   <= 1'b0;
            respawn      <= 1'b0;
        end else begin
            state        <= state_n;
            pellets_left <= pellets_n;
            power_timer  <= power_n;
            grace_timer  <= grace_n;
            score        <= score_n;
            lives        <= lives_n;
            Win          <= win_n;
            loss         <= loss_n;
            power_mode   <= (power_n != '0);
            respawn      <= respawn_n;
        end
    end

endmodule

// File: tb/tb_game_status_tracker.sv
// Scoreboard bench: a cycle model pushes expected outputs, compared after each clock edge.
module tb_game_status_tracker;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [1:0]  game_state = 2'b00;
    logic        pellet_eaten = 1'b0, power_eaten = 1'b0, ghost_collide = 1'b0;
    logic        Win, loss, power_mode, respawn;
    logic [15:0] score;
    logic [1:0]  lives;

    logic        sat_pellet = 1'b0;
    logic        win_s, loss_s, pm_s, resp_s;
    logic [15:0] score_s;
    logic [1:0]  lives_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        win, loss, pm, resp;
        logic [15:0] score;
        logic [1:0]  lives;
    } exp_t;
    exp_t exp_q[$];

    // Model state: st 0 idle, 1 play, 2 grace, 3 done
    int m_st, m_pel, m_score, m_lives, m_pwr, m_grace;
    bit m_win, m_loss, m_resp;

    always #5 Clk = ~Clk;

    game_status_tracker u_dut (
        .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten), .ghost_collide(ghost_collide),
        .Win(Win), .loss(loss), .score(score), .lives(lives),
        .power_mode(power_mode), .respawn(respawn)
    );

    // Large pellet value reaches the 16-bit ceiling within a few events.
    game_status_tracker #(.PELLET_POINTS(2621)) u_sat (
        .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .game_state(game_state),
        .pellet_eaten(sat_pellet), .power_eaten(1'b0), .ghost_collide(1'b0),
        .Win(win_s), .loss(loss_s), .score(score_s), .lives(lives_s),
        .power_mode(pm_s), .respawn(resp_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_clear();
        m_pel = 240; m_score = 0; m_lives = 3; m_pwr = 0; m_grace = 0;
        m_win = 0; m_loss = 0;
    endtask

    task automatic model_step();
        int add;
        int st0;
        bit pm0;
        m_resp = 0;
        if (reset) begin
            model_clear(); m_st = 0;
        end else if (m_st == 0) begin
            model_clear();
            if (game_state == 2'b01) m_st = 1;
        end else if (m_st == 3 || game_state != 2'b01) begin
            if (game_state == 2'b00) begin model_clear(); m_st = 0; end
        end else begin
            add = 0; st0 = m_st; pm0 = (m_pwr != 0);
            if ((pellet_eaten || power_eaten) && m_pel > 0) begin
                m_pel--;
                add = power_eaten ? 50 : 10;
                if (power_eaten) m_pwr = 360;
                else if (frame_tick && m_pwr > 0) m_pwr--;
            end else if (frame_tick && m_pwr > 0) m_pwr--;
            if (st0 == 2 && frame_tick) begin
                m_grace--;
                if (m_grace == 0) m_st = 1;
            end
            if (st0 == 1 && frame_tick && ghost_collide) begin
                if (pm0) begin
                    add += 200; m_grace = 120; m_st = 2;
                end else if (m_pel != 0) begin
                    m_lives--; m_resp = 1; m_pwr = 0; m_grace = 120; m_st = 2;
                end
            end
            m_score = (m_score + add > 65535) ? 65535 : m_score + add;
            if (m_pel == 0) begin m_win = 1; m_st = 3; end
            else if (m_lives == 0) begin m_loss = 1; m_st = 3; end
        end
    endtask

    task automatic cyc(input bit pe = 0, input bit pw = 0, input bit gc = 0,
                       input bit ft = 0, input bit sp = 0);
        exp_t e, o;
        @(negedge Clk);
        pellet_eaten = pe; power_eaten = pw; ghost_collide = gc;
        frame_tick = ft; sat_pellet = sp;
        @(posedge Clk);
        model_step();
        e.win = m_win; e.loss = m_loss; e.pm = (m_pwr != 0); e.resp = m_resp;
        e.score = 16'(m_score); e.lives = 2'(m_lives);
        exp_q.push_back(e);
        #1;
        o = exp_q.pop_front();
        check("win", 32'(Win), 32'(o.win));
        check("loss", 32'(loss), 32'(o.loss));
        check("score", 32'(score), 32'(o.score));
        check("lives", 32'(lives), 32'(o.lives));
        check("power_mode", 32'(power_mode), 32'(o.pm));
        check("respawn", 32'(respawn), 32'(o.resp));
    endtask

    task automatic restart();
        game_state = 2'b00; cyc();
        game_state = 2'b01; cyc();
    endtask

    initial begin
        m_st = 0; model_clear(); m_resp = 0;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 3);

        // Clear the level with 240 pellets
        restart();
        for (int i = 0; i < 240; i++) cyc(1);
        check("t1_win", 32'(Win), 1);
        check("t1_score", 32'(score), 2400);
        check("t1_loss", 32'(loss), 0);
        game_state = 2'b11;
        for (int i = 0; i < 3; i++) cyc(1);
        check("t1_hold", 32'(Win), 1);
        game_state = 2'b00; cyc();
        check("t1_clr_score", 32'(score), 0);
        check("t1_clr_lives", 32'(lives), 3);

        // Three lethal collisions spaced beyond the grace period
        restart();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 1);
            check("t2_lives", 32'(lives), 32'(2 - k));
            check("t2_respawn", 32'(respawn), 1);
            for (int j = 0; j < 130; j++) begin cyc(0, 0, 0, 1); cyc(); end
        end
        check("t2_loss", 32'(loss), 1);

        // Grace period immunity
        restart();
        cyc(0, 0, 1, 1);
        for (int i = 1; i <= 119; i++) cyc(0, 0, 1, 1);
        check("t3_grace", 32'(lives), 2);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        check("t3_after", 32'(lives), 1);

        // Ghost eaten in power mode, then power expiry
        restart();
        cyc(0, 1);
        cyc(0, 0, 1, 1);
        check("t4_score", 32'(score), 250);
        check("t4_lives", 32'(lives), 3);
        check("t4_pm", 32'(power_mode), 1);
        for (int i = 2; i <= 359; i++) cyc(0, 0, 0, 1);
        check("t4_pm359", 32'(power_mode), 1);
        cyc(0, 0, 0, 1);
        check("t4_pm360", 32'(power_mode), 0);

        // Last pellet coincides with a lethal collision
        restart();
        for (int i = 0; i < 239; i++) cyc(1);
        cyc(1, 0, 1, 1);
        check("t5_win", 32'(Win), 1);
        check("t5_loss", 32'(loss), 0);
        check("t5_lives", 32'(lives), 3);
        check("t5_respawn", 32'(respawn), 0);

        // Score saturation on the high-value instance
        restart();
        for (int i = 0; i < 25; i++) cyc(0, 0, 0, 0, 1);
        check("t6_near", 32'(score_s), 32'h0000FFF5);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        check("t6_sat", 32'(score_s), 32'h0000FFFF);

        // Reset in the middle of play
        for (int i = 0; i < 5; i++) cyc(1);
        cyc(0, 1);
        reset = 1'b1; cyc(1, 1, 1, 1);
        reset = 1'b0;
        check("t7_score", 32'(score), 0);
        check("t7_pm", 32'(power_mode), 0);
        check("t7_lives", 32'(lives), 3);
        check("t7_win", 32'(Win), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
